// File: rtl/proc_spi_loader.sv
// Host-side serial loader/runner for the tiny processor's uio pins: shifts
// 12-bit {data, addr} frames LSB-first, launches runs and waits for DONE.
module proc_spi_loader #(
    parameter int                   GAP_CYCLES = 1,
    parameter int                   TIMEOUT_W  = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_type,
    input  logic [3:0]           cmd_addr,
    input  logic [7:0]           cmd_data,
    output logic [1:0]           sel_out,
    output logic                 mosi_out,
    input  logic                 proc_done_in,
    output logic                 run_done_out,
    output logic                 timeout_out,
    output logic [TIMEOUT_W-1:0] run_cycles_out
);
    localparam int         GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [1:0] CMD_ILOAD = 2'b00;
    localparam logic [1:0] CMD_DLOAD = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, RUN_START, RUN_BUSY} state_t;
    state_t state, state_nxt;

    logic [11:0]          frame;
    logic [3:0]           bit_cnt;
    logic [GW-1:0]        gap_cnt;
    logic                 is_dload;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 accept, in_run, last_bit, gap_end, done_hit, tmo_hit;

    assign accept   = cmd_valid & cmd_ready;
    assign in_run   = (state == RUN_START) || (state == RUN_BUSY);
    assign last_bit = (bit_cnt == 4'd11);
    assign gap_end  = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign done_hit = (state == RUN_BUSY) && proc_done_in;
    // Run states last at most TIMEOUT cycles counted from the accept edge.
    assign tmo_hit  = in_run && (tmo_cnt == TIMEOUT - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        sel_out   = 2'b00;
        mosi_out  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_type == CMD_ILOAD || cmd_type == CMD_DLOAD) state_nxt = SHIFT;
                    else if (cmd_type == CMD_RUN)                       state_nxt = RUN_START;
                    else                                                state_nxt = GAP;
                end
            end
            SHIFT: begin
                sel_out  = is_dload ? 2'b10 : 2'b01;
                mosi_out = frame[0];
                if (last_bit) state_nxt = GAP;
            end
            GAP: begin
                if (gap_end) state_nxt = IDLE;
            end
            RUN_START: begin
                sel_out = 2'b11;
                if (tmo_hit)            state_nxt = GAP;
                else if (!proc_done_in) state_nxt = RUN_BUSY;
            end
            RUN_BUSY: begin
                // sel must drop the cycle after DONE or the core restarts
                sel_out = 2'b11;
                if (proc_done_in || tmo_hit) state_nxt = GAP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame          <= '0;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
            is_dload       <= 1'b0;
            tmo_cnt        <= '0;
            run_cycles_out <= '0;
            run_done_out   <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            run_done_out <= done_hit;
            timeout_out  <= tmo_hit && !done_hit;
            gap_cnt      <= (state == GAP) ? gap_cnt + 1'b1 : '0;

            if (accept) begin
                frame    <= {cmd_data, cmd_addr};
                is_dload <= (cmd_type == CMD_DLOAD);
            end else if (state == SHIFT) begin
                frame   <= frame >> 1;
                bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            end

            // run_cycles counts every run-state cycle with DONE low, saturating.
            if (accept && cmd_type == CMD_RUN) begin
                tmo_cnt        <= '0;
                run_cycles_out <= '0;
            end else if (in_run) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (!proc_done_in && run_cycles_out != '1)
                    run_cycles_out <= run_cycles_out + 1'b1;
            end
        end
    end
endmodule

// File: doc/proc_spi_loader.md
Name: proc_spi_loader

Overview:
- Host-side master for the tiny processor's serial load/run pins: serialises instruction and data words onto MOSI, drives the 2-bit select/enable code, launches execution and waits for DONE.
- Sits on the controlling side (FPGA demo harness or a companion tile) and connects directly to the processor's uio[2:0] inputs and uio[3] DONE output.
- Host side is a single-command valid/ready interface.

Parameters:
- GAP_CYCLES, 1, idle cycles (select = 00) inserted after every transfer or run; minimum 1.
- TIMEOUT_W, 16, width of run-timeout counter and cycle counter.
- TIMEOUT, 16'hFFFF, run abort limit in cycles, counted from run accept.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  high only in IDLE; reset value 1
- cmd_type  in  2  00 ILOAD, 01 DLOAD, 10 RUN, 11 NOP
- cmd_addr  in  4  cache address for ILOAD/DLOAD
- cmd_data  in  8  cache word for ILOAD/DLOAD
- sel_out  out  2  to processor uio[1:0]: 00 idle, 01 icache select, 10 dcache select, 11 run; reset 00
- mosi_out  out  1  to processor uio[2]; reset 0
- proc_done_in  in  1  from processor uio[3]; same clock domain, sampled directly
- run_done_out  out  1  one-cycle pulse when a run completes normally; reset 0
- timeout_out  out  1  one-cycle pulse when a run is aborted; reset 0
- run_cycles_out  out  TIMEOUT_W  cycles proc_done_in was low during the last run; reset 0

Behaviour:
- Reset is asynchronous: all registers and outputs go to their reset values immediately.
- States: IDLE, SHIFT, GAP, RUN_START, RUN_BUSY.
- A command is accepted on a rising edge with cmd_valid & cmd_ready; the 12-bit frame {cmd_data, cmd_addr} is captured.

ILOAD/DLOAD:
- Next cycle: SHIFT, sel_out = 01 (I) or 10 (D).
- Exactly 12 cycles in SHIFT; mosi_out carries frame bit 0 first through bit 11 last (LSB first; address nibble first).
- A 4-bit bit counter runs 0..11; after bit 11 go to GAP.
- GAP: sel_out = 00, mosi_out = 0 for GAP_CYCLES cycles, then IDLE. The processor commits the word during the first GAP cycle.
- Accept at edge 0 gives sel active over cycles 1..12, GAP from cycle 13, cmd_ready high again at cycle 13+GAP_CYCLES.

RUN:
- Next cycle: RUN_START, sel_out = 11, mosi_out = 0; run_cycles_out and the timeout counter are cleared.
- RUN_START: wait for proc_done_in = 0, then go to RUN_BUSY.
- RUN_BUSY: run_cycles_out increments each cycle (saturating at all-ones). On proc_done_in = 1, go to GAP with sel_out = 00 and pulse run_done_out in the first GAP cycle.
- sel_out must drop to 00 right after DONE rises; otherwise the processor re-enters execution.

Timeout:
- The counter increments in RUN_START and RUN_BUSY.
- On reaching TIMEOUT: go to GAP, pulse timeout_out, no run_done_out; run_cycles_out keeps its value.
- If DONE rises and timeout hits in the same cycle, the done path wins.

NOP: accepted; goes straight to GAP with no pin activity.

Invariants:
- cmd_ready is low in every non-IDLE state.
- sel_out never changes directly between two non-zero codes; at least GAP_CYCLES of 00 separate them.
- mosi_out = 0 outside SHIFT.

Reset mid-SHIFT: sel_out drops to 00, so the processor still writes its partially shifted buffer to the previously selected cache. This is a known limitation; the host must reissue the load.

Test Plan:
- Reset, then ILOAD addr 5 data A3 -> sel_out = 01 for 12 cycles; mosi sequence 1,0,1,0,1,1,0,0,0,1,0,1; GAP 1 cycle; cmd_ready back at cycle 14; processor icache[5] = A3.
- Back-to-back DLOAD addr F data 80, then DLOAD addr 0 data 7F with cmd_valid held -> exactly GAP_CYCLES of sel 00 between frames; dcache[F] = 80, dcache[0] = 7F.
- Load a 16-instruction program ending in a not-taken branch, then RUN -> sel 11; DONE falls one cycle later; run_done_out pulses once; run_cycles_out equals the EXEC cycle count; sel_out is 00 on the cycle after DONE rises.
- RUN with proc_done_in forced to 0 and TIMEOUT = 20 -> timeout_out pulses 20 cycles after accept, sel_out returns to 00, no run_done_out.
- Assert rst_n low during SHIFT bit 6 -> sel_out = 00, mosi_out = 0, cmd_ready = 1 asynchronously; a new ILOAD afterwards completes correctly.
- NOP, and cmd_valid held high during an active frame -> no pin activity for NOP; the second command waits for cmd_ready, with no frame corruption.
